// File: rtl/core_array_stream_if.sv
// Command and readout bus of core_array_stream.
//   opcode/execute/cmd_ready : command input from the sequencer
//   valid_bit/output_bit     : single-bit READ_BIT result
//   out_valid/out_ready/out_data : packed readout word stream
// master = sequencer/consumer side, slave = core_array_stream.
interface core_array_stream_if #(
  parameter int unsigned OUT_WIDTH = 8
) ();
  logic [13:0]          opcode;
  logic                 execute;
  logic                 cmd_ready;
  logic                 valid_bit;
  logic                 output_bit;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_WIDTH-1:0] out_data;

  modport master (
    output opcode, execute, out_ready,
    input  cmd_ready, valid_bit, output_bit, out_valid, out_data
  );

  modport slave (
    input  opcode, execute, out_ready,
    output cmd_ready, valid_bit, output_bit, out_valid, out_data
  );
endinterface

// File: rtl/core_array_stream.sv
// core_array_stream: array of NR_CORES cores on a shared opcode bus with
// additive selection masks; accumulator LSBs are read out one bit at a time,
// packed LSB-first into OUT_WIDTH-bit words and queued in a FIFO_DEPTH FIFO.
// Ports:
//   clk   : rising-edge clock
//   rst   : asynchronous active-high reset
//   s_if  : core_array_stream_if.slave (command, bit readout, word stream)

// Minimal processing core: 11-bit accumulator driven by opcodes with
// opcode[13]=1; opcode[12:11] selects LOAD/ADD/XOR of the 11-bit immediate.
// No reset: the accumulator survives array resets.
module core (
  input  logic        clk,
  input  logic        i_execute,
  input  logic [13:0] i_opcode,
  output logic        o_accu_lsb
);
  localparam int unsigned ACC_W = 11;

  logic [ACC_W-1:0] r_accu;
  logic [ACC_W-1:0] w_imm;

  assign w_imm = i_opcode[ACC_W-1:0];

  // Array-level opcodes (opcode[13]=0) are ignored by the core.
  always_ff @(posedge clk) begin
    if (i_execute && i_opcode[13]) begin
      case (i_opcode[12:11])
        2'b00:   r_accu <= w_imm;
        2'b01:   r_accu <= r_accu + w_imm;
        2'b10:   r_accu <= r_accu ^ w_imm;
        default: r_accu <= r_accu;
      endcase
    end
  end

  assign o_accu_lsb = r_accu[0];
endmodule

module core_array_stream #(
  parameter int unsigned NR_CORES   = 4,
  parameter int unsigned OUT_WIDTH  = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic             clk,
  input logic             rst,
  core_array_stream_if.slave s_if
);
  localparam int unsigned FILL_W = $clog2(OUT_WIDTH + 1);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);

  logic [NR_CORES-1:0]  r_mask;
  logic [NR_CORES-1:0]  w_core_exec;
  logic [NR_CORES-1:0]  w_accu_lsb;
  logic [NR_CORES-1:0]  w_sel_oh;

  logic [OUT_WIDTH-1:0] r_pack;
  logic [FILL_W-1:0]    r_fill;
  logic                 r_valid_bit;
  logic                 r_output_bit;

  logic [OUT_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [CNT_W-1:0]     r_count;

  logic                 w_fifo_full;
  logic                 w_out_valid;
  logic                 w_accept;
  logic                 w_is_arr;
  logic [4:0]           w_idx;
  logic [7:0]           w_code;
  logic                 w_do_sel;
  logic                 w_do_add;
  logic                 w_do_all;
  logic                 w_do_read;
  logic                 w_do_flush;
  logic                 w_bit;
  logic [OUT_WIDTH-1:0] w_pack_set;
  logic [FILL_W-1:0]    w_fill_inc;
  logic                 w_word_done;
  logic                 w_push;
  logic [OUT_WIDTH-1:0] w_push_data;
  logic                 w_pop;

  // Command acceptance and array opcode decode.
  assign w_fifo_full = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_accept    = s_if.execute & ~w_fifo_full;
  assign w_is_arr    = w_accept & ~s_if.opcode[13];
  assign w_idx       = s_if.opcode[12:8];
  assign w_code      = s_if.opcode[7:0];
  assign w_do_sel    = w_is_arr & (w_code == 8'hBF);
  assign w_do_add    = w_is_arr & (w_code == 8'h3F);
  assign w_do_all    = w_is_arr & (w_code == 8'hFF);
  assign w_do_read   = w_is_arr & (w_code == 8'h7F);
  assign w_do_flush  = w_is_arr & (w_code == 8'h5F);

  // Core instances; w_sel_oh is one-hot(idx) and all-zero for idx >= NR_CORES,
  // which covers the out-of-range SELECT, SELECT_ADD and READ_BIT cases.
  for (genvar y = 0; y < NR_CORES; y++) begin : g_core
    assign w_sel_oh[y]    = (w_idx == 5'(y));
    assign w_core_exec[y] = w_accept & r_mask[y];

    core u_core (
      .clk        (clk),
      .i_execute  (w_core_exec[y]),
      .i_opcode   (s_if.opcode),
      .o_accu_lsb (w_accu_lsb[y])
    );
  end

  assign w_bit = |(w_accu_lsb & w_sel_oh);

  // Packer next-state and FIFO push decision.
  assign w_pack_set  = r_pack | (OUT_WIDTH'(w_bit) << r_fill);
  assign w_fill_inc  = r_fill + FILL_W'(1);
  assign w_word_done = (w_fill_inc == FILL_W'(OUT_WIDTH));
  assign w_push      = (w_do_read & w_word_done) | (w_do_flush & (r_fill != '0));
  assign w_push_data = w_do_read ? w_pack_set : r_pack;

  assign w_out_valid = (r_count != '0);
  assign w_pop       = w_out_valid & s_if.out_ready;

  // Selection mask.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mask <= '1;
    end else if (w_do_sel) begin
      r_mask <= w_sel_oh;
    end else if (w_do_add) begin
      r_mask <= r_mask | w_sel_oh;
    end else if (w_do_all) begin
      r_mask <= '1;
    end
  end

  // Single-bit readout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid_bit  <= 1'b0;
      r_output_bit <= 1'b0;
    end else begin
      r_valid_bit <= w_do_read;
      if (w_do_read) begin
        r_output_bit <= w_bit;
      end
    end
  end

  // Packer: clears whenever its word is pushed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pack <= '0;
      r_fill <= '0;
    end else if (w_push) begin
      r_pack <= '0;
      r_fill <= '0;
    end else if (w_do_read) begin
      r_pack <= w_pack_set;
      r_fill <= w_fill_inc;
    end
  end

  // FIFO storage; contents are masked by out_valid so no reset is needed.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_push_data;
    end
  end

  // FIFO pointers (power-of-two depth wraps naturally) and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign s_if.cmd_ready  = ~w_fifo_full;
  assign s_if.valid_bit  = r_valid_bit;
  assign s_if.output_bit = r_output_bit;
  assign s_if.out_valid  = w_out_valid;
  assign s_if.out_data   = w_out_valid ? r_mem[r_rd_ptr] : '0;
endmodule

// File: tb/tb_core_array_stream.sv
// Scoreboard bench for core_array_stream (NR_CORES=4, OUT_WIDTH=8, FIFO_DEPTH=4).
// Core opcodes (opcode[13]=1): 0x2000|v LOAD, 0x2800|v ADD, 0x3000|v XOR.
module tb_core_array_stream;
  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  core_array_stream_if #(.OUT_WIDTH(8)) bus ();

  core_array_stream #(
    .NR_CORES   (4),
    .OUT_WIDTH  (8),
    .FIFO_DEPTH (4)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .s_if (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_pulses = 0;

  logic [7:0] wq [$];
  logic       bq [$];

  localparam logic [13:0] OP_LOAD  = 14'h2000;
  localparam logic [13:0] OP_XOR   = 14'h3000;

  function automatic logic [13:0] arr(input int idx, input logic [7:0] code);
    logic [4:0] i5;
    i5 = 5'(idx);
    return {1'b0, i5, code};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Word monitor: compares the head word when it is popped.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (wq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_word: got %0h expected none at %0t", bus.out_data, $time);
      end else begin
        chk("word", 32'(bus.out_data), 32'(wq.pop_front()));
      end
    end
  end

  // Bit monitor: compares output_bit on every valid_bit pulse.
  always @(negedge clk) begin
    if (!rst && bus.valid_bit) begin
      n_pulses++;
      if (bq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_valid_bit: got 1 expected 0 at %0t", $time);
      end else begin
        chk("output_bit", 32'(bus.output_bit), 32'(bq.pop_front()));
      end
    end
  end

  // Issue one opcode; caller is just after a rising edge.
  task automatic issue(input logic [13:0] op);
    int k;
    k = 0;
    bus.opcode  = op;
    bus.execute = 1'b1;
    while (!bus.cmd_ready && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    if (!bus.cmd_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL issue_timeout: got cmd_ready 0 expected 1 op %0h", op);
    end
    @(posedge clk); #1;
    bus.execute = 1'b0;
  endtask

  task automatic rd(input int idx, input logic exp);
    bq.push_back(exp);
    issue(arr(idx, 8'h7F));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int p0;
    bus.opcode    = '0;
    bus.execute   = 1'b0;
    bus.out_ready = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(1);

    // Reset mid-operation: mask narrowed, partial word of 2 bits pending.
    issue(OP_LOAD | 14'd1);
    issue(arr(2, 8'hBF));
    rd(0, 1'b1);
    rd(1, 1'b1);
    idle(2);
    rst = 1'b1;
    #1;
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_valid_bit", 32'(bus.valid_bit), 32'd0);
    chk("rst_output_bit", 32'(bus.output_bit), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    idle(2);
    rst = 1'b0;
    idle(1);
    chk("post_rst_output_bit", 32'(bus.output_bit), 32'd0);
    // Partial word was discarded, so FLUSH pushes nothing.
    issue(arr(0, 8'h5F));
    idle(3);
    chk("flush_after_rst", 32'(bus.out_valid), 32'd0);
    // Broadcast reaches all four cores (mask back to 1111).
    issue(OP_LOAD | 14'd0);
    rd(0, 1'b0); rd(1, 1'b0); rd(2, 1'b0); rd(3, 1'b0);
    wq.push_back(8'h00);
    issue(arr(0, 8'h5F));

    // Selection: cores 0 and 2 only.
    issue(arr(2, 8'hBF));
    issue(arr(0, 8'h3F));
    issue(OP_LOAD | 14'd1);
    rd(0, 1'b1); rd(1, 1'b0); rd(2, 1'b1); rd(3, 1'b0);
    wq.push_back(8'h05);
    issue(arr(0, 8'h5F));
    // SELECT 7 gives mask 0, SELECT_ADD 7 leaves it 0: XOR reaches nobody.
    issue(arr(7, 8'hBF));
    issue(arr(7, 8'h3F));
    issue(OP_XOR | 14'd1);
    rd(0, 1'b1); rd(1, 1'b0); rd(2, 1'b1); rd(3, 1'b0);
    issue(arr(0, 8'hFF));
    issue(OP_XOR | 14'd1);
    // LSBs now 0,1,0,1; bits 4..7 complete word 1010_0101.
    rd(0, 1'b0); rd(1, 1'b1); rd(2, 1'b0);
    wq.push_back(8'hA5);
    rd(3, 1'b1);
    rd(9, 1'b0);
    wq.push_back(8'h00);
    issue(arr(0, 8'h5F));
    idle(3);

    // Packing: LSBs c0..c3 = 1,0,1,1, reads 0,1,2,3,0,0,0,0 -> 1111_1101.
    issue(OP_LOAD | 14'd1);
    issue(arr(1, 8'hBF));
    issue(OP_LOAD | 14'd0);
    issue(arr(0, 8'hFF));
    p0 = n_pulses;
    rd(0, 1'b1); rd(1, 1'b0); rd(2, 1'b1); rd(3, 1'b1);
    rd(0, 1'b1); rd(0, 1'b1); rd(0, 1'b1);
    chk("no_word_before_8th", 32'(bus.out_valid), 32'd0);
    wq.push_back(8'hFD);
    rd(0, 1'b1);
    chk("word_latency_valid", 32'(bus.out_valid), 32'd1);
    chk("word_latency_data", 32'(bus.out_data), 32'hFD);
    idle(2);
    chk("pulse_count", 32'(n_pulses - p0), 32'd8);

    // Flush: three 1-bits -> 0x07; a second FLUSH pushes nothing.
    issue(OP_LOAD | 14'd1);
    rd(0, 1'b1); rd(0, 1'b1); rd(0, 1'b1);
    wq.push_back(8'h07);
    issue(arr(0, 8'h5F));
    issue(arr(0, 8'h5F));
    idle(3);
    chk("empty_flush", 32'(bus.out_valid), 32'd0);

    // Backpressure: LSBs 1,0,1,1; fill the FIFO with 01,02,03,04.
    issue(arr(1, 8'hBF));
    issue(OP_LOAD | 14'd0);
    issue(arr(0, 8'hFF));
    bus.out_ready = 1'b0;
    rd(0, 1'b1);
    wq.push_back(8'h01); issue(arr(0, 8'h5F));
    rd(1, 1'b0); rd(0, 1'b1);
    wq.push_back(8'h02); issue(arr(0, 8'h5F));
    rd(0, 1'b1); rd(0, 1'b1);
    wq.push_back(8'h03); issue(arr(0, 8'h5F));
    rd(1, 1'b0); rd(1, 1'b0); rd(0, 1'b1);
    wq.push_back(8'h04); issue(arr(0, 8'h5F));
    chk("full_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    chk("full_head", 32'(bus.out_data), 32'h01);
    // Blocked opcodes: LOAD 0, SELECT 7, READ_BIT must all be ignored.
    bus.execute = 1'b1;
    bus.opcode = OP_LOAD | 14'd0; idle(3);
    bus.opcode = arr(7, 8'hBF);   idle(3);
    bus.opcode = arr(0, 8'h7F);   idle(3);
    chk("blocked_valid_bit", 32'(bus.valid_bit), 32'd0);
    bus.execute = 1'b0;
    chk("stable_head", 32'(bus.out_data), 32'h01);
    bus.out_ready = 1'b1;
    #1;
    chk("pop_cycle_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    idle(1);
    chk("after_pop_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    idle(5);
    // Mask still 1111 and c0 still 1: XOR 1 gives c0=0, c1=1.
    issue(OP_XOR | 14'd1);
    rd(0, 1'b0); rd(1, 1'b1);
    wq.push_back(8'h02);
    issue(arr(0, 8'h5F));
    idle(3);

    // Simultaneous push/pop with count 1.
    bus.out_ready = 1'b0;
    rd(1, 1'b1);
    wq.push_back(8'h01);
    issue(arr(0, 8'h5F));
    for (int j = 0; j < 7; j++) rd(0, 1'b0);
    bus.out_ready = 1'b1;
    wq.push_back(8'h80);
    rd(1, 1'b1);
    chk("pushpop_valid", 32'(bus.out_valid), 32'd1);
    chk("pushpop_data", 32'(bus.out_data), 32'h80);
    idle(2);

    // Pointer wrap: ten 4-bit words with intermittent backpressure.
    for (int n = 1; n <= 10; n++) begin
      logic [3:0] v;
      v = 4'(n);
      bus.out_ready = ((n % 3) != 0);
      for (int j = 0; j < 4; j++) rd(v[j] ? 1 : 0, v[j]);
      wq.push_back({4'h0, v});
      issue(arr(0, 8'h5F));
    end
    bus.out_ready = 1'b1;
    idle(10);
    chk("words_left", 32'(wq.size()), 32'd0);
    chk("bits_left", 32'(bq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
